// File: rtl/fixed_point_addsub_serial_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fixed_point_pkg
// Description : FSM state encoding and saturation constants shared by the
//               serial fixed-point adder/subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
package fixed_point_pkg;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    // Results are 64 bits wide; callers keep the low 'width' bits.
    function automatic logic [63:0] max_pos(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] max_neg(input int width);
        return 64'd1 << (width - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fixed_point_addsub_serial_if.sv
`default_nettype none
// ============================================================================
// Module      : fixed_point_addsub_serial_if
// Description : Request/result bundle of the serial adder/subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
interface fixed_point_addsub_serial_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             op;
    logic             sat_en;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             overflow;
    logic             ovf_sticky;

    modport master (
        output start, a, b, op, sat_en,
        input  busy, done, sum, overflow, ovf_sticky
    );

    modport slave (
        input  start, a, b, op, sat_en,
        output busy, done, sum, overflow, ovf_sticky
    );
endinterface
`default_nettype wire

// File: rtl/fixed_point_addsub_serial_chunk_add.sv
`default_nettype none
// ============================================================================
// Module      : fixed_point_chunk_add
// Description : CHUNK-wide adder slice with carry in, carry out and the carry
//               into its top bit (for signed overflow detection).
// Revision    : 1.0 - initial release
// ============================================================================
module fixed_point_chunk_add #(
    parameter int CHUNK = 4
) (
    input  wire logic [CHUNK-1:0] i_a,
    input  wire logic [CHUNK-1:0] i_b,
    input  wire logic             i_cin,
    output logic      [CHUNK-1:0] o_sum,
    output logic                  o_cout,
    output logic                  o_cmsb
);
    logic [CHUNK:0] w_full;

    assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_cin};
    assign o_sum  = w_full[CHUNK-1:0];
    assign o_cout = w_full[CHUNK];
    // Top sum bit = a ^ b ^ carry-in, so the carry-in is recovered by XOR.
    assign o_cmsb = w_full[CHUNK-1] ^ i_a[CHUNK-1] ^ i_b[CHUNK-1];
endmodule
`default_nettype wire

// File: rtl/fixed_point_addsub_serial.sv
`default_nettype none
// ============================================================================
// Module      : fixed_point_addsub_serial
// Description : Two's-complement add/subtract processed CHUNK bits per clock,
//               with optional saturation on signed overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module fixed_point_addsub_serial
    import fixed_point_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int CHUNK       = 4,
    parameter int SAT_DEFAULT = 0
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    fixed_point_addsub_serial_if.slave  bus
);
    localparam int c_NCHUNK = (CHUNK >= 1) ? (WIDTH / CHUNK) : 1;
    localparam int c_IDX_W  = (c_NCHUNK > 1) ? $clog2(c_NCHUNK) : 1;
    localparam logic [WIDTH-1:0] c_SAT_POS = WIDTH'(max_pos(WIDTH));
    localparam logic [WIDTH-1:0] c_SAT_NEG = WIDTH'(max_neg(WIDTH));

    generate
        if (CHUNK < 1) begin : g_bad_chunk
            $error("CHUNK must be at least 1");
        end else if ((WIDTH % CHUNK) != 0) begin : g_bad_width
            $error("WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    logic [1:0]         r_state;
    logic [c_IDX_W-1:0] r_idx;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic               r_sat;
    logic [WIDTH-1:0]   r_part;
    logic [WIDTH-1:0]   r_sum;
    logic               r_ovf;
    logic               r_sticky;

    logic [CHUNK-1:0]   w_slice;
    logic               w_cout;
    logic               w_cmsb;
    logic               w_last;
    logic               w_ovf;
    logic [WIDTH-1:0]   w_wrap;
    logic [WIDTH-1:0]   w_final;

    fixed_point_chunk_add #(.CHUNK(CHUNK)) u_chunk_add (
        .i_a    (r_a[r_idx*CHUNK +: CHUNK]),
        .i_b    (r_b[r_idx*CHUNK +: CHUNK]),
        .i_cin  (r_carry),
        .o_sum  (w_slice),
        .o_cout (w_cout),
        .o_cmsb (w_cmsb)
    );

    assign w_last = (r_idx == c_IDX_W'(c_NCHUNK - 1));
    assign w_ovf  = w_cmsb ^ w_cout;

    // The final slice is the top one; lower slices are already in r_part.
    always_comb begin
        w_wrap                   = r_part;
        w_wrap[WIDTH-1 -: CHUNK] = w_slice;
    end

    assign w_final = (w_ovf && r_sat) ? (r_a[WIDTH-1] ? c_SAT_NEG : c_SAT_POS)
                                      : w_wrap;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_idx    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_carry  <= 1'b0;
            r_sat    <= (SAT_DEFAULT != 0);
            r_part   <= '0;
            r_sum    <= '0;
            r_ovf    <= 1'b0;
            r_sticky <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b ^ {WIDTH{bus.op}};
                        r_carry <= bus.op;
                        r_sat   <= bus.sat_en;
                        r_idx   <= '0;
                        r_state <= c_BUSY;
                    end else begin
                        r_state <= c_IDLE;
                    end
                end
                c_BUSY: begin
                    r_part[r_idx*CHUNK +: CHUNK] <= w_slice;
                    r_carry                      <= w_cout;
                    if (w_last) begin
                        r_sum    <= w_final;
                        r_ovf    <= w_ovf;
                        r_sticky <= r_sticky | w_ovf;
                        r_idx    <= '0;
                        r_state  <= c_DONE;
                    end else begin
                        r_idx <= r_idx + c_IDX_W'(1);
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign bus.busy       = (r_state == c_BUSY);
    assign bus.done       = (r_state == c_DONE);
    assign bus.sum        = r_sum;
    assign bus.overflow   = r_ovf;
    assign bus.ovf_sticky = r_sticky;
endmodule
`default_nettype wire
